// File: rtl/mips_io_pkg.sv
// Shared definitions for the memory-mapped I/O port unit: register offsets
// within the 16-byte window and STATUS bit positions.
package mips_io_pkg;

    localparam logic [3:0] IO_OUT    = 4'h0;
    localparam logic [3:0] IO_IN     = 4'h4;
    localparam logic [3:0] IO_STATUS = 4'h8;
    localparam logic [3:0] IO_CLR    = 4'hC;

    localparam int STATUS_CHANGED_BIT = 0;
    localparam int STATUS_BUSY_BIT    = 1;
    localparam int CLR_CHANGED_BIT    = 0;

endpackage

// File: rtl/mips_io_port_unit_if.sv
// Load/store bus between the MIPS datapath (master) and the I/O port unit (slave).
interface mips_io_port_unit_if;

    logic        MemWrite;
    logic        MemRead;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        Hit;

    modport master (
        output MemWrite, MemRead, Address, WriteData,
        input  ReadData, Hit
    );

    modport slave (
        input  MemWrite, MemRead, Address, WriteData,
        output ReadData, Hit
    );

endinterface

// File: rtl/io_input_debouncer.sv
// Two-flop synchroniser followed by a counting debouncer; a new input value is
// accepted only after DEBOUNCE_CYCLES consecutive samples differ from the current one.
module io_input_debouncer
    import mips_io_pkg::*;
#(
    parameter int IN_WIDTH        = 8,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [IN_WIDTH-1:0] port_in,
    output logic [IN_WIDTH-1:0] debounced,
    output logic                accept,
    output logic                busy
);

    localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [IN_WIDTH-1:0] sync1_q, sync1_d;
    logic [IN_WIDTH-1:0] sync2_q, sync2_d;
    logic [IN_WIDTH-1:0] debounced_q, debounced_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                differ;

    // NOTE: every signal written here gets a value before any branch, so no latch is inferred.
    always_comb begin
        differ      = (sync2_q != debounced_q);
        accept      = differ && (cnt_q == CNT_LAST);
        busy        = differ;
        sync1_d     = port_in;
        sync2_d     = sync1_q;
        debounced_d = debounced_q;
        cnt_d       = '0;
        if (accept) begin
            debounced_d = sync2_q;
        end else if (differ) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            debounced_q <= '0;
            cnt_q       <= '0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            debounced_q <= debounced_d;
            cnt_q       <= cnt_d;
        end
    end

    assign debounced = debounced_q;

endmodule

// File: rtl/mips_io_port_unit.sv
// Memory-mapped I/O stage after the ALU: address decode, PortOut register,
// sticky input-change flag and a combinational load-data mux.
module mips_io_port_unit
    import mips_io_pkg::*;
#(
    parameter int          IN_WIDTH        = 8,
    parameter int          DEBOUNCE_CYCLES = 4,
    parameter logic [31:0] BASE_ADDR       = 32'h1001_0000
) (
    input  logic                clk,
    input  logic                reset,
    mips_io_port_unit_if.slave  bus,
    input  logic [IN_WIDTH-1:0] PortIn,
    output logic [31:0]         PortOut,
    output logic                InChange
);

    logic                hit;
    logic [3:0]          offset;
    logic                rd_hit;
    logic                wr_hit;
    logic                clear_changed;
    logic [31:0]         port_out_q, port_out_d;
    logic                changed_q, changed_d;
    logic [31:0]         in_word;
    logic [31:0]         status_word;
    logic [31:0]         read_data;
    logic [IN_WIDTH-1:0] debounced;
    logic                accept;
    logic                busy;

    io_input_debouncer #(
        .IN_WIDTH        (IN_WIDTH),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_deb (
        .clk       (clk),
        .reset     (reset),
        .port_in   (PortIn),
        .debounced (debounced),
        .accept    (accept),
        .busy      (busy)
    );

    always_comb begin
        offset = bus.Address[3:0];
        hit    = (bus.Address[31:4] == BASE_ADDR[31:4]) && (bus.Address[1:0] == 2'b00);
        rd_hit = hit && bus.MemRead;
        wr_hit = hit && bus.MemWrite;

        clear_changed = (rd_hit && offset == IO_STATUS) ||
                        (wr_hit && offset == IO_CLR && bus.WriteData[CLR_CHANGED_BIT]);

        port_out_d = (wr_hit && offset == IO_OUT) ? bus.WriteData : port_out_q;

        // A fresh acceptance on the same edge as a clear keeps the flag set.
        changed_d = changed_q;
        if (accept) begin
            changed_d = 1'b1;
        end else if (clear_changed) begin
            changed_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            port_out_q <= '0;
            changed_q  <= 1'b0;
        end else begin
            port_out_q <= port_out_d;
            changed_q  <= changed_d;
        end
    end

    always_comb begin
        in_word                        = '0;
        in_word[IN_WIDTH-1:0]          = debounced;
        status_word                    = '0;
        status_word[STATUS_CHANGED_BIT] = changed_q;
        status_word[STATUS_BUSY_BIT]    = busy;
        read_data                      = '0;
        if (rd_hit) begin
            case (offset)
                IO_OUT:    read_data = port_out_q;
                IO_IN:     read_data = in_word;
                IO_STATUS: read_data = status_word;
                default:   read_data = '0;
            endcase
        end
    end

    assign bus.ReadData = read_data;
    assign bus.Hit      = hit;
    assign PortOut      = port_out_q;
    assign InChange     = changed_q;

endmodule
